// File: rtl/row_readout_ctrl_pkg.sv
// Shared configuration for the pixel-array row readout path.
// Holds the default array geometry, the read latency, the readout FSM
// state type and a small width helper used by the readout modules.
package PixelSensorConfig;

    localparam int PIXEL_ARRAY_WIDTH  = 4;
    localparam int PIXEL_ARRAY_HEIGHT = 4;
    localparam int PIXEL_BITS         = 8;
    localparam int READ_LATENCY       = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        WAIT_BUF = 3'd2,
        LOAD     = 3'd3,
        DONE     = 3'd4
    } readout_state_t;

    // Width of an index counting 0..n-1; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_readout_ctrl_decoder.sv
// Row select decoder: turns the current row number into the one-hot
// row enable for the pixel array. All rows are released when the
// enable is low.
module row_select_decoder #(
    parameter int HEIGHT = 4,
    parameter int IDX_W  = 2
) (
    input  logic [IDX_W-1:0]  row_index,
    input  logic              enable,
    output logic [HEIGHT-1:0] row_select
);

    // One-hot decode gated by the enable.
    always_comb begin
        row_select = '0;
        for (int i = 0; i < HEIGHT; i++) begin
            row_select[i] = enable && (row_index == IDX_W'(i));
        end
    end

endmodule

// File: rtl/row_readout_ctrl.sv
// Row readout controller: walks the pixel array one row at a time,
// waits the array read latency, then hands each row to the output
// buffer with a one-cycle load strobe, and pulses frame_done at the end.
// Optional build macro READOUT_TEST_PATTERN_EN replaces the captured
// pixel data with a row/column ramp so the downstream path can be
// exercised without a live sensor.
module row_readout_ctrl #(
    parameter int PIXEL_ARRAY_WIDTH  = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
    parameter int PIXEL_ARRAY_HEIGHT = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
    parameter int PIXEL_BITS         = PixelSensorConfig::PIXEL_BITS,
    parameter int READ_LATENCY       = PixelSensorConfig::READ_LATENCY
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]     pixel_data,
    input  logic                                        buffer_ready,
    output logic [PIXEL_ARRAY_HEIGHT-1:0]               row_select,
    output logic [PixelSensorConfig::idx_width(PIXEL_ARRAY_HEIGHT)-1:0] row_index,
    output logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]     data_out,
    output logic                                        set_buffer,
    output logic                                        busy,
    output logic                                        frame_done
);

    import PixelSensorConfig::*;

    localparam int IDX_W    = idx_width(PIXEL_ARRAY_HEIGHT);
    localparam int CNT_W    = idx_width(READ_LATENCY);
    localparam int ROW_BITS = PIXEL_ARRAY_WIDTH * PIXEL_BITS;

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LATENCY - 1);

    readout_state_t      state;
    readout_state_t      state_nxt;
    logic [CNT_W-1:0]    lat_cnt;
    logic                sel_en;
    logic                frame_start;
    logic                capture;
    logic                row_advance;
    logic [ROW_BITS-1:0] capture_data;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and Moore outputs decoded from the current state.
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        sel_en      = 1'b0;
        set_buffer  = 1'b0;
        busy        = 1'b1;
        frame_done  = 1'b0;
        frame_start = 1'b0;
        capture     = 1'b0;
        row_advance = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    frame_start = 1'b1;
                    state_nxt   = SELECT;
                end
            end
            SELECT: begin
                sel_en = 1'b1;
                if (lat_cnt == LAST_CNT) begin
                    state_nxt = WAIT_BUF;
                end
            end
            WAIT_BUF: begin
                sel_en = 1'b1;
                if (buffer_ready) begin
                    capture   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                set_buffer = 1'b1;
                if (row_index < LAST_ROW) begin
                    row_advance = 1'b1;
                    state_nxt   = SELECT;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Row number and read-latency counter; row_index keeps the last row
    // after a frame until the next start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_index <= '0;
            lat_cnt   <= '0;
        end else begin
            if (frame_start) begin
                row_index <= '0;
                lat_cnt   <= '0;
            end else if (row_advance) begin
                row_index <= row_index + 1'b1;
                lat_cnt   <= '0;
            end else if (state == SELECT && lat_cnt != LAST_CNT) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
        end
    end

    // Row capture register; only loads on the WAIT_BUF to LOAD step so
    // the buffer sees stable data for the whole strobe cycle.
    // NOTE: this wide register is reset explicitly because the buffer
    // side must observe all-zero data while the block is held in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (capture) begin
            data_out <= capture_data;
        end
    end

`ifdef READOUT_TEST_PATTERN_EN
    // Live pixel data is not used when the ramp pattern is selected.
    logic unused_pixel_data;
    assign unused_pixel_data = ^pixel_data;

    // Ramp pattern: pixel i of row r carries (i + r) modulo 2^PIXEL_BITS.
    always_comb begin
        capture_data = '0;
        for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin
            capture_data[i*PIXEL_BITS +: PIXEL_BITS] =
                PIXEL_BITS'(i + int'(row_index));
        end
    end
`else
    assign capture_data = pixel_data;
`endif

    row_select_decoder #(
        .HEIGHT (PIXEL_ARRAY_HEIGHT),
        .IDX_W  (IDX_W)
    ) u_row_select_decoder (
        .row_index  (row_index),
        .enable     (sel_en),
        .row_select (row_select)
    );

endmodule

// File: tb/tb_row_readout_ctrl.sv
// Testbench for row_readout_ctrl with a 4x4 array, 8-bit pixels and a
// read latency of 2. A behavioural pixel array answers row_select, the
// expected rows of each frame are queued when the frame is started and
// a monitor pops and compares them on every load strobe.
module tb_row_readout_ctrl;

    localparam int W       = 4;
    localparam int H       = 4;
    localparam int B       = 8;
    localparam int L       = 2;
    localparam int IW      = 2;
    localparam int RB      = W * B;
    localparam int ROW_T   = L + 2;
    localparam int FRAME_T = H * ROW_T;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          buffer_ready = 1'b1;
    logic [RB-1:0] pixel_data;
    logic [H-1:0]  row_select;
    logic [IW-1:0] row_index;
    logic [RB-1:0] data_out;
    logic          set_buffer;
    logic          busy;
    logic          frame_done;

    int total = 0;
    int bad   = 0;
    int seed  = 0;
    int cyc   = 0;

    logic [RB-1:0] exp_q[$];
    int            load_cyc_q[$];
    int            done_cnt = 0;
    int            done_cyc = -1;

    row_readout_ctrl #(
        .PIXEL_ARRAY_WIDTH  (W),
        .PIXEL_ARRAY_HEIGHT (H),
        .PIXEL_BITS         (B),
        .READ_LATENCY       (L)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pixel_data   (pixel_data),
        .buffer_ready (buffer_ready),
        .row_select   (row_select),
        .row_index    (row_index),
        .data_out     (data_out),
        .set_buffer   (set_buffer),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel value presented by the array for row r, column i.
    function automatic logic [B-1:0] pix_val(input int r, input int i, input int s);
        int v;
        v = (s == 0) ? r : (r * 16 + i + s);
        return B'(v);
    endfunction

    // Row the controller is expected to hand to the buffer.
    function automatic logic [RB-1:0] exp_row(input int r, input int s);
        logic [RB-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) begin
`ifdef READOUT_TEST_PATTERN_EN
            v[i*B +: B] = B'(i + r);
`else
            v[i*B +: B] = pix_val(r, i, s);
`endif
        end
        return v;
    endfunction

    // Behavioural pixel array driven by the row enables.
    always_comb begin
`ifdef READOUT_TEST_PATTERN_EN
        pixel_data = '1;
`else
        pixel_data = {W{8'hA5}};
        for (int r = 0; r < H; r++) begin
            if (row_select[r]) begin
                for (int i = 0; i < W; i++) begin
                    pixel_data[i*B +: B] = pix_val(r, i, seed);
                end
            end
        end
`endif
    end

    // Scoreboard monitor: compare each loaded row, log strobe and done cycles.
    always @(negedge clk) begin : monitor
        logic [RB-1:0] e;
        if (rst_n) begin
            if (set_buffer) begin
                total++;
                load_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_load cyc=%0d data_out=%h expected no strobe", cyc, data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        bad++;
                        $display("FAIL load_data cyc=%0d got=%h exp=%h", cyc, data_out, e);
                    end
                end
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // Start a frame: queue its expected rows, pulse start for one edge.
    task automatic start_frame(output int c0);
        @(negedge clk);
        start = 1'b1;
        for (int r = 0; r < H; r++) exp_q.push_back(exp_row(r, seed));
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
    endtask

    // Compare strobe cycles and frame_done of one frame against timing.
    task automatic expect_frame(input int c0, input int stall_row, input int stall, input string name);
        int e;
        total++;
        if (load_cyc_q.size() != H) begin
            bad++;
            $display("FAIL %s_load_count got=%0d exp=%0d", name, load_cyc_q.size(), H);
        end
        for (int r = 0; r < H && r < load_cyc_q.size(); r++) begin
            e = c0 + (L + 1) + r * ROW_T + ((r >= stall_row) ? stall : 0);
            total++;
            if (load_cyc_q[r] !== e) begin
                bad++;
                $display("FAIL %s_load_cycle row=%0d got=%0d exp=%0d", name, r, load_cyc_q[r] - c0, e - c0);
            end
        end
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL %s_done_count got=%0d exp=1", name, done_cnt);
        end
        total++;
        if (done_cyc !== c0 + FRAME_T + stall) begin
            bad++;
            $display("FAIL %s_done_cycle got=%0d exp=%0d", name, done_cyc - c0, FRAME_T + stall);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_rows_left got=%0d exp=0", name, exp_q.size());
        end
        load_cyc_q.delete();
        exp_q.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({row_select, row_index, data_out, set_buffer, busy, frame_done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {row_select, row_index, data_out, set_buffer, busy, frame_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || row_select !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle busy=%b row_select=%b exp busy=0 row_select=0000", busy, row_select);
        end
    endtask

    task automatic test_basic_frame();
        int c0;
        logic [RB-1:0] last;
        seed = 0;
        start_frame(c0);
        total++;
        if (row_select !== 4'b0001 || row_index !== 2'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_first_select row_select=%b row_index=%0d busy=%b exp 0001/0/1",
                     row_select, row_index, busy);
        end
        repeat (FRAME_T + 2) @(negedge clk);
`ifdef READOUT_TEST_PATTERN_EN
        last = 32'h06050403;
`else
        last = 32'h03030303;
`endif
        total++;
        if (data_out !== last) begin
            bad++;
            $display("FAIL basic_last_row got=%h exp=%h", data_out, last);
        end
        total++;
        if (row_index !== 2'd3 || busy !== 1'b0 || row_select !== 4'b0000) begin
            bad++;
            $display("FAIL basic_after_frame row_index=%0d busy=%b row_select=%b exp 3/0/0000",
                     row_index, busy, row_select);
        end
        expect_frame(c0, H, 0, "basic");
    endtask

    task automatic test_buffer_stall();
        int c0;
        logic [RB-1:0] row0;
        seed = 7;
        row0 = exp_row(0, seed);
        start_frame(c0);
        repeat (6) @(negedge clk);
        buffer_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (row_select !== 4'b0010 || set_buffer !== 1'b0 || data_out !== row0) begin
                bad++;
                $display("FAIL stall_hold k=%0d row_select=%b set_buffer=%b data_out=%h exp 0010/0/%h",
                         k, row_select, set_buffer, data_out, row0);
            end
        end
        buffer_ready = 1'b1;
        repeat (FRAME_T + 12 - 16) @(negedge clk);
        expect_frame(c0, 1, 10, "stall");
    endtask

    task automatic test_start_ignored();
        int c0;
        seed = 3;
        start_frame(c0);
        for (int k = 1; k <= FRAME_T + 4; k++) begin
            @(negedge clk);
            if (k >= FRAME_T + 1) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL ignore_busy_low cycle=%0d got=%b exp=0", k + 1, busy);
                end
            end
            start = (k == 2 || k == 8 || k == 16);
        end
        start = 1'b0;
        expect_frame(c0, H, 0, "ignore");
    endtask

    task automatic test_reset_mid_frame();
        int c0;
        int c1;
        seed = 9;
        start_frame(c0);
        repeat (8) @(negedge clk);
        total++;
        if (row_select !== 4'b0100) begin
            bad++;
            $display("FAIL midrst_row2 got=%b exp=0100", row_select);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({row_select, row_index, data_out, set_buffer, busy, frame_done} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs got=%h exp=0",
                     {row_select, row_index, data_out, set_buffer, busy, frame_done});
        end
        total++;
        if (load_cyc_q.size() != 2) begin
            bad++;
            $display("FAIL midrst_rows_before got=%0d exp=2", load_cyc_q.size());
        end
        exp_q.delete();
        load_cyc_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME_T) @(negedge clk);
        total++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_abandoned done_cnt=%0d busy=%b exp 0/0", done_cnt, busy);
        end
        start_frame(c1);
        total++;
        if (row_select !== 4'b0001 || row_index !== 2'd0) begin
            bad++;
            $display("FAIL midrst_restart row_select=%b row_index=%0d exp 0001/0", row_select, row_index);
        end
        repeat (FRAME_T + 2) @(negedge clk);
        expect_frame(c1, H, 0, "restart");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_buffer_stall();
        test_start_ignored();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/row_readout_ctrl.md
ROW_READOUT_CTRL -- requirements
Module: row_readout_ctrl

Interface
REQ-001 SHALL have parameter PIXEL_ARRAY_WIDTH, default PixelSensorConfig::PIXEL_ARRAY_WIDTH, pixels per row.
REQ-002 SHALL have parameter PIXEL_ARRAY_HEIGHT, default PixelSensorConfig::PIXEL_ARRAY_HEIGHT, rows per frame (>=1).
REQ-003 SHALL have parameter PIXEL_BITS, default PixelSensorConfig::PIXEL_BITS, bits per pixel.
REQ-004 SHALL have parameter READ_LATENCY, default PixelSensorConfig::READ_LATENCY (2), cycles from row select to valid PIXEL_DATA (>=1).
REQ-005 CLK  in  1  single clock, all state on rising edge.
REQ-006 RESET  in  1  asynchronous, active-low reset.
REQ-007 START  in  1  frame readout request, sampled only in IDLE.
REQ-008 PIXEL_DATA  in  PIXEL_ARRAY_WIDTH x PIXEL_BITS  selected row from pixel array.
REQ-009 BUFFER_READY  in  1  output buffer idle, may accept a row.
REQ-010 ROW_SELECT  out  PIXEL_ARRAY_HEIGHT  one-hot row enable to pixel array.
REQ-011 ROW_INDEX  out  $clog2(PIXEL_ARRAY_HEIGHT) (min 1)  current row number.
REQ-012 DATA_OUT  out  PIXEL_ARRAY_WIDTH x PIXEL_BITS  registered row to output buffer DATA_IN.
REQ-013 SET_BUFFER  out  1  one-cycle load strobe to output buffer.
REQ-014 BUSY  out  1  high in every state except IDLE.
REQ-015 FRAME_DONE  out  1  one-cycle pulse after last row loaded.

Function
REQ-016 FSM states SHALL be IDLE, SELECT, WAIT_BUF, LOAD, DONE.
REQ-017 IDLE -> SELECT when START=1; ROW_INDEX<=0, latency counter<=0.
REQ-018 SELECT SHALL last exactly READ_LATENCY cycles, then -> WAIT_BUF.
REQ-019 WAIT_BUF with BUFFER_READY=1 SHALL capture PIXEL_DATA into DATA_OUT and -> LOAD; with BUFFER_READY=0 SHALL hold indefinitely.
REQ-020 SET_BUFFER SHALL be 1 exactly in LOAD (Moore), with DATA_OUT already stable that cycle.
REQ-021 LOAD -> SELECT with ROW_INDEX+1 if ROW_INDEX < PIXEL_ARRAY_HEIGHT-1, else -> DONE.
REQ-022 DONE SHALL assert FRAME_DONE one cycle, then -> IDLE; ROW_INDEX holds last row value until next START.
REQ-023 ROW_SELECT SHALL be one-hot of ROW_INDEX in SELECT and WAIT_BUF, all-zero in IDLE, LOAD, DONE.
REQ-024 START outside IDLE SHALL be ignored (no queuing); START high in DONE does not restart.
REQ-025 Per-row time with BUFFER_READY constantly high SHALL be READ_LATENCY+2 cycles; START sampled at edge k gives FRAME_DONE high in cycle k+1+PIXEL_ARRAY_HEIGHT*(READ_LATENCY+2).
REQ-026 DATA_OUT SHALL change only on WAIT_BUF->LOAD transition.
REQ-027 PIXEL_ARRAY_HEIGHT=1 SHALL go LOAD -> DONE after the single row.

Reset
REQ-028 RESET=0 SHALL immediately force IDLE, ROW_INDEX=0, counter=0, DATA_OUT=0, ROW_SELECT=0, SET_BUFFER=0, BUSY=0, FRAME_DONE=0, regardless of CLK.
REQ-029 Reset mid-frame SHALL abandon the frame with no FRAME_DONE; next START restarts at row 0.

Configuration
REQ-030 Macro READOUT_TEST_PATTERN_EN defined: WAIT_BUF capture SHALL use pixel[i] = (i + ROW_INDEX) mod 2^PIXEL_BITS instead of PIXEL_DATA; PIXEL_DATA ignored.
REQ-031 Macro undefined: PIXEL_DATA captured; no pattern logic present.

Structure
REQ-032 PixelSensorConfig SHALL hold PIXEL_ARRAY_HEIGHT, READ_LATENCY and typedef readout_state_t (enum of the five states).
REQ-033 One sub-module row_select_decoder SHALL convert ROW_INDEX plus enable to one-hot ROW_SELECT.

Verification (WIDTH=4, HEIGHT=4, BITS=8, LATENCY=2)
REQ-034 RESET=0 mid-SELECT of row 2 -> all outputs zero without clock edge; START afterwards -> ROW_SELECT=0001, ROW_INDEX=0.
REQ-035 START pulse at edge 0, BUFFER_READY=1, PIXEL_DATA={r,r,r,r} for selected row r -> four SET_BUFFER pulses in cycles 4,8,12,16, DATA_OUT rows 0..3 in order, FRAME_DONE in cycle 17 only.
REQ-036 BUFFER_READY=0 for 10 cycles in row 1 WAIT_BUF -> ROW_SELECT=0010 held, no SET_BUFFER, DATA_OUT unchanged; FRAME_DONE delayed by 10 cycles.
REQ-037 START pulsed in cycles 3, 9 and 17 of a frame -> ignored; exactly one FRAME_DONE, BUSY low from cycle 18.
REQ-038 With READOUT_TEST_PATTERN_EN, PIXEL_DATA=0xFF -> row 3 DATA_OUT = {3,4,5,6} for pixels 0..3.
